// File: rtl/tt_sweep_driver.sv
// -----------------------------------------------------------------------------
// tt_sweep_driver
//
// Stimulus/capture stage for a 3-input, 1-output combinational truth-table
// block. On start it walks the block inputs through all eight combinations,
// holds each one for SETTLE_CYCLES clocks, samples the block output at the
// end of every hold, and then compares the captured 8-row table against an
// expected table that was latched at start.
//
// Optional build macro: TT_SWEEP_STABILITY_EN
//   Adds a second, earlier sample per row (one cycle before the final
//   sample) and reports rows whose two samples disagree on o_unstable.
//   Any unstable row forces o_pass low.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before it is sampled.
//                  Legal range 1 .. 2**CNT_W-1; 0 is not a legal value.
//   CNT_W          width of the settle counter.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst        synchronous, active-high reset
//   i_start      begin a sweep (honoured only when idle)
//   i_abort      cancel a sweep in progress; beats i_start when idle
//   i_expected   golden table, bit i = required output for vector i
//   i_dut_out    output of the truth-table block
//   o_in1..o_in3 vector to the block, o_in1 = MSB
//   o_busy       high while vectors are being held
//   o_done       one-cycle pulse when a sweep completes
//   o_captured   bit i = sampled block output for vector i
//   o_mismatch   o_captured XOR latched expected, valid from o_done
//   o_pass       mismatch-free (and stable, if enabled), valid from o_done
//   o_unstable   (TT_SWEEP_STABILITY_EN only) rows whose two samples differ
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for start; results of the last sweep are held
//   ST_HOLD   | driving vector r_idx, counting settle cycles
//   ST_FINISH | one-cycle done pulse; results already registered
// -----------------------------------------------------------------------------
module tt_sweep_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [7:0] i_expected,
    input  logic       i_dut_out,
    output logic       o_in1,
    output logic       o_in2,
    output logic       o_in3,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_captured,
    output logic [7:0] o_mismatch,
    output logic       o_pass
`ifdef TT_SWEEP_STABILITY_EN
    ,
    output logic [7:0] o_unstable
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_exp;
    logic [7:0]       r_captured;
    logic [7:0]       r_mismatch;
    logic             r_pass;

    logic             w_start_ok;
    logic             w_abort;
    logic             w_sample;
    logic             w_last;
    logic [7:0]       w_cap_nxt;
    logic             w_stable_ok;

    assign w_start_ok = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_abort    = (r_state != ST_IDLE) && i_abort;
    assign w_sample   = (r_state == ST_HOLD) && (r_cnt == LP_CNT_LAST);
    assign w_last     = w_sample && (r_idx == 3'd7);

    // Captured table including the row being sampled this edge, so the final
    // compare can be registered on the same edge as the last sample.
    always_comb begin
        w_cap_nxt        = r_captured;
        w_cap_nxt[r_idx] = i_dut_out;
    end

`ifdef TT_SWEEP_STABILITY_EN
    // The early sample sits one cycle before the final one; it only exists
    // when the hold is at least two cycles long.
    localparam logic             LP_HAS_EARLY = (SETTLE_CYCLES >= 2);
    localparam int               LP_EARLY_INT = (SETTLE_CYCLES >= 2) ? (SETTLE_CYCLES - 2) : 0;
    localparam logic [CNT_W-1:0] LP_CNT_EARLY = CNT_W'(LP_EARLY_INT);

    logic       r_early;
    logic [7:0] r_unstable;
    logic [7:0] w_unst_nxt;
    logic       w_early_smp;

    assign w_early_smp = LP_HAS_EARLY && (r_state == ST_HOLD) && (r_cnt == LP_CNT_EARLY);

    always_comb begin
        w_unst_nxt = r_unstable;
        if (LP_HAS_EARLY) begin
            w_unst_nxt[r_idx] = r_early ^ i_dut_out;
        end
    end

    assign w_stable_ok = (w_unst_nxt == 8'h00);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_early <= 1'b0;
        end else if (w_early_smp) begin
            r_early <= i_dut_out;
        end
    end

    assign o_unstable = r_unstable;
`else
    assign w_stable_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sweep datapath: vector index, settle counter and result registers.
    // r_idx is forced back to 0 whenever a sweep ends so the vector outputs
    // read 000 outside HOLD without any extra gating.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_exp      <= 8'h00;
            r_captured <= 8'h00;
            r_mismatch <= 8'h00;
            r_pass     <= 1'b0;
`ifdef TT_SWEEP_STABILITY_EN
            r_unstable <= 8'h00;
`endif
        end else if (w_abort) begin
            // Partial rows in r_captured are intentionally kept.
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_mismatch <= 8'h00;
            r_pass     <= 1'b0;
        end else if (w_start_ok) begin
            r_exp      <= i_expected;
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_captured <= 8'h00;
            r_mismatch <= 8'h00;
            r_pass     <= 1'b0;
`ifdef TT_SWEEP_STABILITY_EN
            r_unstable <= 8'h00;
`endif
        end else if (r_state == ST_HOLD) begin
            if (w_sample) begin
                r_captured <= w_cap_nxt;
                r_cnt      <= '0;
`ifdef TT_SWEEP_STABILITY_EN
                r_unstable <= w_unst_nxt;
`endif
                if (w_last) begin
                    r_idx      <= 3'd0;
                    r_mismatch <= w_cap_nxt ^ r_exp;
                    r_pass     <= (w_cap_nxt == r_exp) && w_stable_ok;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_in1      = r_idx[2];
    assign o_in2      = r_idx[1];
    assign o_in3      = r_idx[0];
    assign o_captured = r_captured;
    assign o_mismatch = r_mismatch;
    assign o_pass     = r_pass;

endmodule
